// File: rtl/ntt_bfly_lanes.sv
// ntt_bfly_lanes: LANES independent Kyber butterflies (CT, GS with halving, or
// bypass) that share one valid/mode delay line. Every sample takes the same
// fixed number of enabled cycles regardless of mode, so modes can be mixed
// back-to-back. A single enable freezes the whole pipeline, outputs included.
module ntt_bfly_lanes #(
  parameter int WID   = 12,
  parameter int Q     = 3329,
  parameter int LANES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [1:0]           mode,
  input  logic [LANES*WID-1:0] u,
  input  logic [LANES*WID-1:0] t,
  input  logic [LANES*WID-1:0] w,
  output logic                 out_valid,
  output logic [LANES*WID-1:0] s0,
  output logic [LANES*WID-1:0] s1
);

  // The multiplier is split over two ranks: the twiddle times the low and
  // high halves of the operand, then a shifted sum.
  localparam int H   = WID / 2;
  localparam int PLW = WID + H;
  localparam int PHW = 2 * WID - H;
  localparam int PW  = 2 * WID;
  // Barrett constant floor(2^(2*WID) / Q). With a shift of 2*WID the quotient
  // estimate is low by at most one, so a single conditional subtract is enough.
  localparam int MW  = 2 * WID + 1;
  localparam int FW  = PW + MW;
  localparam logic [WID:0]    QE = (WID + 1)'(Q);
  localparam logic [MW-1:0]   MU = MW'((64'd1 << PW) / 64'(Q));

  // (a + b) mod Q from a WID+1 bit sum and one conditional subtract
  function automatic logic [WID-1:0] add_mod(input logic [WID-1:0] a, input logic [WID-1:0] b);
    logic [WID:0] sum_s;
    sum_s = {1'b0, a} + {1'b0, b};
    return (sum_s >= QE) ? WID'(sum_s - QE) : WID'(sum_s);
  endfunction

  // (a - b) mod Q from a WID+1 bit difference and one conditional add
  function automatic logic [WID-1:0] sub_mod(input logic [WID-1:0] a, input logic [WID-1:0] b);
    logic [WID:0] diff_s;
    diff_s = {1'b0, a} - {1'b0, b};
    return diff_s[WID] ? WID'(diff_s + QE) : WID'(diff_s);
  endfunction

  // a * 2^-1 mod Q without a multiplier: odd values borrow one Q first
  function automatic logic [WID-1:0] halve_mod(input logic [WID-1:0] a);
    return a[0] ? WID'(({1'b0, a} + QE) >> 1) : (a >> 1);
  endfunction

  // Rank i holds the valid/mode of the sample currently in datapath rank i.
  logic [7:1] vld_r;
  logic [1:0] mode_r [1:6];
  logic       bypass2_s, ct2_s, bypass7_s, ct7_s;

  // Valid/mode delay line: shifts on en, valid bits cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r <= 7'd0;
      for (int i = 1; i <= 6; i++) mode_r[i] <= 2'd0;
    end else if (en) begin
      vld_r     <= {vld_r[6:1], in_valid};
      mode_r[1] <= mode;
      for (int i = 2; i <= 6; i++) mode_r[i] <= mode_r[i-1];
    end
  end

  assign out_valid = vld_r[7];
  assign bypass2_s = mode_r[1][1];
  assign ct2_s     = mode_r[1][0];
  assign bypass7_s = mode_r[6][1];
  assign ct7_s     = mode_r[6][0];

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WID-1:0] u1_r, t1_r, w1_r;
    logic [WID-1:0] x2_s, op2_s;
    logic [WID-1:0] x2_r, op2_r, y2_r, w2_r;
    logic [PLW-1:0] pplo3_r;
    logic [PHW-1:0] pphi3_r;
    logic [WID-1:0] x3_r, y3_r;
    logic [PW-1:0]  prod4_r;
    logic [WID-1:0] x4_r, y4_r;
    logic [FW-1:0]  full5_s;
    logic [PW-1:0]  prod5_r;
    logic [WID-1:0] qest5_r, x5_r, y5_r;
    logic [PW-1:0]  qq6_s, r6_s;
    logic [WID:0]   rem6_s;
    logic [WID-1:0] p6_s, p6_r, x6_r, y6_r;
    logic [WID-1:0] s0_s, s1_s, s0_r, s1_r;
    logic           unused_s;

    // GS pre add/sub; CT and bypass pass u/t through untouched
    always_comb begin
      x2_s  = u1_r;
      op2_s = t1_r;
      if (!bypass2_s && !ct2_s) begin
        x2_s  = add_mod(u1_r, t1_r);
        op2_s = sub_mod(u1_r, t1_r);
      end else begin
        x2_s  = u1_r;
        op2_s = t1_r;
      end
    end

    // Barrett quotient estimate from the full product
    always_comb begin
      full5_s = FW'(prod4_r) * FW'(MU);
    end

    // Barrett remainder with its single conditional subtract
    always_comb begin
      qq6_s  = PW'(qest5_r) * PW'(Q);
      r6_s   = prod5_r - qq6_s;
      rem6_s = r6_s[WID:0];
      if (rem6_s >= QE) begin
        rem6_s = rem6_s - QE;
      end else begin
        rem6_s = r6_s[WID:0];
      end
      p6_s = rem6_s[WID-1:0];
    end

    // Final stage: CT post add/sub, GS halving, or verbatim bypass
    always_comb begin
      s0_s = x6_r;
      s1_s = y6_r;
      if (bypass7_s) begin
        s0_s = x6_r;
        s1_s = y6_r;
      end else if (ct7_s) begin
        s0_s = add_mod(x6_r, p6_r);
        s1_s = sub_mod(x6_r, p6_r);
      end else begin
        s0_s = halve_mod(x6_r);
        s1_s = halve_mod(p6_r);
      end
    end

    // Bits of the wide intermediates that the result never needs
    assign unused_s = ^{full5_s[FW-1:PW+WID], full5_s[PW-1:0], r6_s[PW-1:WID+1]};

    // Lane datapath ranks 1..7; all hold while en is low
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        u1_r    <= '0; t1_r <= '0; w1_r <= '0;
        x2_r    <= '0; op2_r <= '0; y2_r <= '0; w2_r <= '0;
        pplo3_r <= '0; pphi3_r <= '0; x3_r <= '0; y3_r <= '0;
        prod4_r <= '0; x4_r <= '0; y4_r <= '0;
        prod5_r <= '0; qest5_r <= '0; x5_r <= '0; y5_r <= '0;
        p6_r    <= '0; x6_r <= '0; y6_r <= '0;
        s0_r    <= '0; s1_r <= '0;
      end else if (en) begin
        u1_r    <= u[k*WID +: WID];
        t1_r    <= t[k*WID +: WID];
        w1_r    <= w[k*WID +: WID];
        x2_r    <= x2_s;
        op2_r   <= op2_s;
        y2_r    <= t1_r;
        w2_r    <= w1_r;
        pplo3_r <= PLW'(w2_r) * PLW'(op2_r[H-1:0]);
        pphi3_r <= PHW'(w2_r) * PHW'(op2_r[WID-1:H]);
        x3_r    <= x2_r;
        y3_r    <= y2_r;
        prod4_r <= PW'(pplo3_r) + (PW'(pphi3_r) << H);
        x4_r    <= x3_r;
        y4_r    <= y3_r;
        prod5_r <= prod4_r;
        qest5_r <= full5_s[PW +: WID];
        x5_r    <= x4_r;
        y5_r    <= y4_r;
        p6_r    <= p6_s;
        x6_r    <= x5_r;
        y6_r    <= y5_r;
        s0_r    <= s0_s;
        s1_r    <= s1_s;
      end
    end

    assign s0[k*WID +: WID] = s0_r;
    assign s1[k*WID +: WID] = s1_r;
  end

endmodule
